matvec_seq_ctrl: RTL and testbench

//  Parameterised sequencer for the matrix-vector datapath (weight RAM, vector RAM, MAC accumulator).

---
 rtl/matvec_pkg.sv | 27 ++
 rtl/matvec_ctrl_dly.sv | 49 ++++
 rtl/matvec_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_matvec_seq_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/matvec_pkg.sv
`default_nettype none
// ============================================================================
// Module : matvec_pkg
// Brief  : Shared FSM state type, default geometry and width helper for the
//          matrix-vector sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package matvec_pkg;

  typedef enum logic [1:0] {
    LOAD_W = 2'd0,
    LOAD_X = 2'd1,
    CALC   = 2'd2,
    OUT    = 2'd3
  } state_t;

  localparam int unsigned C_DEF_M      = 3;
  localparam int unsigned C_DEF_N      = 3;
  localparam int unsigned C_DEF_RD_LAT = 1;

  // Width able to hold 0..v-1; never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage
`default_nettype wire

// File: rtl/matvec_ctrl_dly.sv
`default_nettype none
// ============================================================================
// Module : matvec_ctrl_dly
// Brief  : DEPTH-stage shift register aligning {en, clr} with RAM read data.
// Rev    : 1.0 - initial release
// ============================================================================
module matvec_ctrl_dly #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_in,
  input  logic clr_in,
  output logic en_out,
  output logic clr_out
);

  logic [DEPTH-1:0] r_en_sr;
  logic [DEPTH-1:0] r_clr_sr;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_en_sr  <= '0;
          r_clr_sr <= '0;
        end else begin
          r_en_sr  <= en_in;
          r_clr_sr <= clr_in;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_en_sr  <= '0;
          r_clr_sr <= '0;
        end else begin
          r_en_sr  <= {r_en_sr[DEPTH-2:0], en_in};
          r_clr_sr <= {r_clr_sr[DEPTH-2:0], clr_in};
        end
      end
    end
  endgenerate

  assign en_out  = r_en_sr[DEPTH-1];
  assign clr_out = r_clr_sr[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/matvec_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : matvec_seq_ctrl
// Brief  : Load/compute/output sequencer for an MxN matrix-vector datapath.
// Rev    : 1.0 - initial release
// ============================================================================
module matvec_seq_ctrl
  import matvec_pkg::*;
#(
  parameter int unsigned M      = C_DEF_M,
  parameter int unsigned N      = C_DEF_N,
  parameter int unsigned AW_W   = 6,
  parameter int unsigned AW_X   = 3,
  parameter int unsigned RD_LAT = C_DEF_RD_LAT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            input_valid,
  output logic            input_ready,
  input  logic            new_matrix,
  output logic            output_valid,
  input  logic            output_ready,
  output logic [AW_W-1:0] addr_w,
  output logic            wr_en_w,
  output logic [AW_X-1:0] addr_x,
  output logic            wr_en_x,
  output logic            en_acc,
  output logic            clear_acc
);

  localparam int unsigned C_WC_W = clog2_min1(M * N);
  localparam int unsigned C_XC_W = clog2_min1(N);
  localparam int unsigned C_R_W  = clog2_min1(M);
  localparam int unsigned C_WT_W = clog2_min1(RD_LAT);

  localparam logic [C_WC_W-1:0] C_W_LAST  = C_WC_W'(M * N - 1);
  localparam logic [C_WC_W-1:0] C_W_ONE   = C_WC_W'(1);
  localparam logic [C_XC_W-1:0] C_X_LAST  = C_XC_W'(N - 1);
  localparam logic [C_XC_W-1:0] C_X_ONE   = C_XC_W'(1);
  localparam logic [C_R_W-1:0]  C_R_LAST  = C_R_W'(M - 1);
  localparam logic [C_R_W-1:0]  C_R_ONE   = C_R_W'(1);
  localparam logic [C_WT_W-1:0] C_WT_LAST = C_WT_W'(RD_LAT - 1);
  localparam logic [C_WT_W-1:0] C_WT_ONE  = C_WT_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [C_WC_W-1:0]   r_w_cnt;
  logic [C_XC_W-1:0]   r_x_cnt;
  logic [C_WC_W-1:0]   r_w_idx;
  logic [C_XC_W-1:0]   r_c;
  logic [C_R_W-1:0]    r_row;
  logic [C_WT_W-1:0]   r_wait;
  logic                r_issued;
  logic                r_out_valid;
  logic                r_rst_done;

  logic w_in_xfer;
  logic w_out_xfer;
  logic w_nm_hit;
  logic w_issue;

  assign input_ready  = r_rst_done & ((r_state == LOAD_W) | (r_state == LOAD_X));
  assign w_in_xfer    = input_valid & input_ready;
  assign w_out_xfer   = r_out_valid & output_ready;
  assign w_nm_hit     = (r_state == LOAD_X) & (r_x_cnt == '0) & new_matrix;
  assign w_issue      = (r_state == CALC) & ~r_issued;
  assign output_valid = r_out_valid;

  always_comb begin
    w_state_nxt = r_state;
    wr_en_w     = 1'b0;
    wr_en_x     = 1'b0;
    addr_w      = '0;
    addr_x      = '0;
    case (r_state)
      LOAD_W: begin
        addr_w  = AW_W'(r_w_cnt);
        wr_en_w = w_in_xfer;
        if (w_in_xfer && (r_w_cnt == C_W_LAST)) w_state_nxt = LOAD_X;
      end
      LOAD_X: begin
        if (w_nm_hit) begin
          // First beat of a new matrix lands as weight 0.
          wr_en_w = w_in_xfer;
          if (w_in_xfer) w_state_nxt = LOAD_W;
        end else begin
          addr_x  = AW_X'(r_x_cnt);
          wr_en_x = w_in_xfer;
          if (w_in_xfer && (r_x_cnt == C_X_LAST)) w_state_nxt = CALC;
        end
      end
      CALC: begin
        addr_w = AW_W'(r_w_idx);
        addr_x = AW_X'(r_c);
        if (r_issued && (r_wait == C_WT_LAST)) w_state_nxt = OUT;
      end
      OUT: begin
        addr_w = AW_W'(r_w_idx);
        addr_x = AW_X'(r_c);
        if (w_out_xfer) w_state_nxt = (r_row == C_R_LAST) ? LOAD_X : CALC;
      end
      default: w_state_nxt = LOAD_W;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= LOAD_W;
      r_rst_done  <= 1'b0;
      r_w_cnt     <= '0;
      r_x_cnt     <= '0;
      r_w_idx     <= '0;
      r_c         <= '0;
      r_row       <= '0;
      r_wait      <= '0;
      r_issued    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_rst_done <= 1'b1;
      r_state    <= w_state_nxt;
      case (r_state)
        LOAD_W: begin
          if (w_in_xfer) r_w_cnt <= (r_w_cnt == C_W_LAST) ? '0 : r_w_cnt + C_W_ONE;
        end
        LOAD_X: begin
          if (w_in_xfer) begin
            if (w_nm_hit) begin
              r_w_cnt <= C_W_ONE;
            end else if (r_x_cnt == C_X_LAST) begin
              r_x_cnt  <= '0;
              r_row    <= '0;
              r_c      <= '0;
              r_w_idx  <= '0;
              r_issued <= 1'b0;
              r_wait   <= '0;
            end else begin
              r_x_cnt <= r_x_cnt + C_X_ONE;
            end
          end
        end
        CALC: begin
          // Issue phase walks the row; then drain the read pipeline.
          if (!r_issued) begin
            if (r_c == C_X_LAST) begin
              r_issued <= 1'b1;
            end else begin
              r_c     <= r_c + C_X_ONE;
              r_w_idx <= r_w_idx + C_W_ONE;
            end
          end else if (r_wait == C_WT_LAST) begin
            r_wait      <= '0;
            r_out_valid <= 1'b1;
          end else begin
            r_wait <= r_wait + C_WT_ONE;
          end
        end
        OUT: begin
          if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_issued    <= 1'b0;
            if (r_row == C_R_LAST) begin
              r_row   <= '0;
              r_w_idx <= '0;
            end else begin
              r_row   <= r_row + C_R_ONE;
              r_w_idx <= r_w_idx + C_W_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  matvec_ctrl_dly #(
    .DEPTH (RD_LAT)
  ) u_dly (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_in   (w_issue),
    .clr_in  (w_issue & (r_c == '0)),
    .en_out  (en_acc),
    .clr_out (clear_acc)
  );

endmodule
`default_nettype wire

// File: tb/tb_matvec_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_matvec_seq_ctrl
// Brief  : Directed bench for matvec_seq_ctrl with a behavioural RAM/MAC model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_matvec_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       input_valid = 1'b0;
  logic       new_matrix = 1'b0;
  logic       output_ready = 1'b0;
  logic [7:0] in_data = 8'd0;

  logic       input_ready, output_valid, wr_en_w, wr_en_x, en_acc, clear_acc;
  logic [5:0] addr_w;
  logic [2:0] addr_x;

  int checks = 0;
  int errors = 0;

  int wmem [64];
  int xmem [8];
  int prod = 0;
  int acc  = 0;

  matvec_seq_ctrl #(.M(3), .N(3), .AW_W(6), .AW_X(3), .RD_LAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .new_matrix   (new_matrix),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .addr_w       (addr_w),
    .wr_en_w      (wr_en_w),
    .addr_x       (addr_x),
    .wr_en_x      (wr_en_x),
    .en_acc       (en_acc),
    .clear_acc    (clear_acc)
  );

  always #5 clk = ~clk;

  // Datapath model: RAMs with one-cycle registered product feeding the MAC.
  always @(posedge clk) begin
    if (wr_en_w) wmem[addr_w] <= int'(in_data);
    if (wr_en_x) xmem[addr_x] <= int'(in_data);
    prod <= wmem[addr_w] * xmem[addr_x];
    if (en_acc) acc <= clear_acc ? prod : acc + prod;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {20'd0, input_ready, output_valid, wr_en_w, wr_en_x, en_acc, clear_acc,
              addr_w[2:0], addr_x} | {26'd0, addr_w}, 32'd0);
  endtask

  task automatic beat(input int d, input bit nm, input bit exp_w, input int exp_a);
    input_valid = 1'b1;
    in_data     = d[7:0];
    new_matrix  = nm;
    #1;
    chk("beat_ready", input_ready, 1);
    chk("beat_wr_w", wr_en_w, exp_w);
    chk("beat_wr_x", wr_en_x, !exp_w);
    chk("beat_addr", exp_w ? 32'(addr_w) : 32'(addr_x), exp_a);
    @(negedge clk);
    input_valid = 1'b0;
    new_matrix  = 1'b0;
  endtask

  task automatic gap();
    input_valid = 1'b0;
    #1;
    chk("gap_wr", {wr_en_w, wr_en_x}, 0);
    @(negedge clk);
  endtask

  task automatic calc_row(input int row, input int exp, input int hold);
    for (int k = 0; k < 4; k++) begin
      input_valid = 1'b1;
      in_data     = 8'd99;
      #1;
      chk("calc_ready", input_ready, 0);
      chk("calc_wr", {wr_en_w, wr_en_x}, 0);
      chk("calc_ov", output_valid, 0);
      chk("calc_en", en_acc, k >= 1);
      chk("calc_clr", clear_acc, k == 1);
      if (k < 3) begin
        chk("calc_ax", addr_x, k);
        chk("calc_aw", addr_w, row * 3 + k);
      end
      @(negedge clk);
    end
    input_valid = 1'b0;
    #1;
    chk("out_ov", output_valid, 1);
    chk("out_en", en_acc, 0);
    chk("out_data", acc, exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      chk("hold_ov", output_valid, 1);
      chk("hold_en", en_acc, 0);
      chk("hold_data", acc, exp);
      chk("hold_aw", addr_w, row * 3 + 2);
    end
    output_ready = 1'b1;
    @(negedge clk);
    output_ready = 1'b0;
    #1;
    chk("post_ov", output_valid, 0);
  endtask

  initial begin
    // Reset: outputs quiet even with a beat offered
    #12;
    input_valid = 1'b1;
    #1;
    all_zero("reset_outs");
    chk("reset_ready", input_ready, 0);
    input_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_ready", input_ready, 0);
    @(negedge clk);
    #1;
    chk("ready_up", input_ready, 1);

    // Weights 1..9 with two bubbles; new_matrix ignored while loading weights
    for (int i = 0; i < 9; i++) begin
      if (i == 3 || i == 6) gap();
      beat(i + 1, i == 4, 1'b1, i);
    end
    beat(1, 1'b0, 1'b0, 0);
    beat(2, 1'b0, 1'b0, 1);
    beat(3, 1'b0, 1'b0, 2);

    calc_row(0, 14, 0);
    calc_row(1, 32, 5);
    calc_row(2, 50, 0);
    #1;
    chk("back_to_x", input_ready, 1);

    // New matrix: diag(2); new_matrix on x beat 1 is a plain vector write
    beat(2, 1'b1, 1'b1, 0);
    for (int i = 1; i < 9; i++) begin
      beat((i == 4 || i == 8) ? 2 : 0, i == 2, 1'b1, i);
    end
    beat(1, 1'b0, 1'b0, 0);
    beat(5, 1'b1, 1'b0, 1);
    beat(7, 1'b0, 1'b0, 2);
    calc_row(0, 2, 0);
    calc_row(1, 10, 0);
    calc_row(2, 14, 0);

    // Reset in the middle of CALC
    beat(1, 1'b0, 1'b0, 0);
    beat(1, 1'b0, 1'b0, 1);
    beat(1, 1'b0, 1'b0, 2);
    @(negedge clk);
    #1;
    chk("mid_en", en_acc, 1);
    rst_n = 1'b0;
    #1;
    all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(3, 1'b1, 1'b1, 0);
    beat(4, 1'b0, 1'b1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
